shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 77 +++++++
 tb/tb_shift_add_multiplier.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-add multiplier, one partial product per cycle,
// with a one-cycle registered write strobe for the downstream product register.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] prod_d,
    output logic               prod_we,
    output logic               busy,
    output logic               done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_n;
    logic [2*WIDTH-1:0] acc, acc_n, prod_n;
    logic [WIDTH-1:0]   mcand_r, mcand_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH:0]     upper;
    logic               we_n;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        mcand_n = mcand_r;
        cnt_n   = cnt;
        prod_n  = prod_d;
        we_n    = 1'b0;
        // Upper-half sum keeps its carry; it becomes the new MSB after the shift.
        upper   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand_r : {WIDTH{1'b0}})};
        case (state)
            IDLE: if (start) begin
                state_n = CALC;
                mcand_n = multiplicand;
                acc_n   = {{WIDTH{1'b0}}, multiplier};
                cnt_n   = '0;
            end
            CALC: begin
                acc_n = {upper, acc[WIDTH-1:1]};
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                    prod_n  = acc_n;
                    we_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand_r <= '0;
            cnt     <= '0;
            prod_d  <= '0;
            prod_we <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mcand_r <= mcand_n;
            cnt     <= cnt_n;
            prod_d  <= prod_n;
            prod_we <= we_n;
            done    <= we_n;
            busy    <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scenario tasks compare the DUT against a plain a*b reference
// and against the expected latency/pulse timing.
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic [63:0] prod_d;
    logic        prod_we, busy, done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
        .multiplier(multiplier), .prod_d(prod_d), .prod_we(prod_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Starts one multiply and follows it through E33; when poke is set, start is
    // re-asserted with 9*9 at E10 and during the DONE cycle to probe the busy lockout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit poke,
                         output logic [63:0] p, output int lat, output int npulse,
                         output bit busy_e0, output bit busy_end, output int pcyc, output bit done_ok);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        busy_e0 = busy;
        lat = -1; npulse = 0; p = '0; pcyc = -1; done_ok = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (prod_we) begin
                npulse++; lat = i; p = prod_d; pcyc = cyc;
            end
            if (done !== prod_we) done_ok = 1'b0;
            if (poke && (i == 9 || i == 32)) begin
                start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
            end
        end
        start = 1'b0;
        busy_end = busy;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({prod_d, prod_we, busy, done} !== 67'd0) begin
            errors++; $display("FAIL reset_async: got prod_d=%h we=%b busy=%b done=%b want all 0", prod_d, prod_we, busy, done);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({prod_d, prod_we, busy, done} !== 67'd0) begin
            errors++; $display("FAIL reset_idle: got prod_d=%h we=%b busy=%b done=%b want all 0", prod_d, prod_we, busy, done);
        end
    endtask

    task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p; int lat, np, pc; bit b0, be, dk;
        do_op(a, b, 1'b0, p, lat, np, b0, be, pc, dk);
        checks++;
        if (p !== ref_mul(a, b) || np != 1) begin
            errors++; $display("FAIL %s_prod: a=%h b=%h got %h (pulses %0d) want %h (1 pulse)", name, a, b, p, np, ref_mul(a, b));
        end
        checks++;
        if (lat != 32 || !b0 || be || !dk) begin
            errors++; $display("FAIL %s_timing: got lat=%0d busy_e0=%b busy_end=%b done_ok=%b want 32/1/0/1", name, lat, b0, be, dk);
        end
    endtask

    task automatic test_basic;
        test_mul("basic", 32'd3, 32'd5);
        checks++;
        if (prod_d !== 64'h0000_0000_0000_000F) begin
            errors++; $display("FAIL basic_hold: got %h want 000000000000000f", prod_d);
        end
    endtask

    task automatic test_max;
        test_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (prod_d !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL max_const: got %h want fffffffe00000001", prod_d);
        end
        test_mul("msb", 32'h8000_0000, 32'd2);
        checks++;
        if (prod_d !== 64'h0000_0001_0000_0000) begin
            errors++; $display("FAIL msb_const: got %h want 0000000100000000", prod_d);
        end
    endtask

    task automatic test_zero;
        test_mul("zero_a", 32'd0, 32'h1234_5678);
        test_mul("zero_b", 32'hDEAD_BEEF, 32'd0);
    endtask

    task automatic test_lockout;
        logic [63:0] p; int lat, np, pc; bit b0, be, dk; int extra = 0;
        do_op(32'd7, 32'd6, 1'b1, p, lat, np, b0, be, pc, dk);
        checks++;
        if (p !== 64'h2A || np != 1 || lat != 32) begin
            errors++; $display("FAIL lockout_prod: got %h pulses=%0d lat=%0d want 2a/1/32", p, np, lat);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy || prod_we) extra++;
        end
        checks++;
        if (extra != 0 || prod_d !== 64'h2A) begin
            errors++; $display("FAIL lockout_idle: got %0d busy/we cycles prod_d=%h want 0 and 2a", extra, prod_d);
        end
    endtask

    task automatic test_reset_midop;
        int stray = 0;
        start = 1'b1; multiplicand = 32'd100; multiplier = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3; rst = 1'b1; #1;
        checks++;
        if ({prod_d, prod_we, busy, done} !== 67'd0) begin
            errors++; $display("FAIL midop_reset: got prod_d=%h we=%b busy=%b done=%b want all 0", prod_d, prod_we, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (prod_we || busy || done) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL midop_no_pulse: got %0d active cycles want 0", stray);
        end
        test_mul("after_reset", 32'd100, 32'd200);
        checks++;
        if (prod_d !== 64'h4E20) begin
            errors++; $display("FAIL after_reset_const: got %h want 4e20", prod_d);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] p1, p2; int l1, l2, n1, n2, c1, c2; bit b0, be, dk;
        do_op(32'd2, 32'd3, 1'b0, p1, l1, n1, b0, be, c1, dk);
        do_op(32'd4, 32'd5, 1'b0, p2, l2, n2, b0, be, c2, dk);
        checks++;
        if (p1 !== 64'd6 || p2 !== 64'd20 || n1 != 1 || n2 != 1) begin
            errors++; $display("FAIL b2b_prod: got %h,%h pulses %0d,%0d want 6,20 one each", p1, p2, n1, n2);
        end
        checks++;
        if (c2 - c1 != 34) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles want 34", c2 - c1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (i % 5 == 0) a = a >> $urandom_range(31, 0);
            test_mul("random", a, b);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_zero;
        test_lockout;
        test_reset_midop;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
